// File: rtl/sram_controller_if.sv
// Request/response bundle between system logic and the SRAM controller.
// The master issues single-word requests; the slave returns read data on a
// one-cycle strobe.
interface sram_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_controller.sv
// Synchronous initiator for an asynchronous single-port SRAM.
// Each request runs SETUP -> PULSE/ACCESS (WAIT_CYCLES long) -> HOLD/DONE -> IDLE.
// Every pin, including the data-bus drive enable, comes straight from a flop,
// and the pin flops are computed from the *next* state so that the pins
// change on the same edge as the state they belong to.
module sram_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_controller_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_chip_enable,
  output logic                  sram_write_enable,
  output logic                  sram_output_enable
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("sram_controller: WAIT_CYCLES must be at least 1");
    end
  endgenerate

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_SETUP  = 3'd1;
  localparam logic [2:0] S_WR_PULSE  = 3'd2;
  localparam logic [2:0] S_WR_HOLD   = 3'd3;
  localparam logic [2:0] S_RD_SETUP  = 3'd4;
  localparam logic [2:0] S_RD_ACCESS = 3'd5;
  localparam logic [2:0] S_RD_DONE   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  ready_q, ready_d;
  logic                  drive_q, drive_d;
  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  accept;

  // Sequencer: next state, wait counter, latched request, read capture, pin values.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    accept      = bus.req_valid && ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = bus.req_write ? S_WR_SETUP : S_RD_SETUP;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        wait_d  = WAIT_LOAD;
      end
      S_WR_PULSE: begin
        if (wait_q == '0) begin
          state_d = S_WR_HOLD;
        end else begin
          wait_d = wait_q - CNT_ONE;
        end
      end
      S_WR_HOLD: state_d = S_IDLE;
      S_RD_SETUP: begin
        state_d = S_RD_ACCESS;
        wait_d  = WAIT_LOAD;
      end
      S_RD_ACCESS: begin
        if (wait_q == '0) begin
          // OE is still low up to this edge, so the device is driving the bus.
          state_d     = S_RD_DONE;
          rsp_valid_d = 1'b1;
          rdata_d     = sram_data;
        end else begin
          wait_d = wait_q - CNT_ONE;
        end
      end
      S_RD_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pin values belong to the state being entered. The bus is only driven
    // in write states, and OE is only low in RD_ACCESS, so the controller
    // and the device never drive together.
    ce_d    = 1'b1;
    we_d    = 1'b1;
    oe_d    = 1'b1;
    drive_d = 1'b0;
    case (state_d)
      S_WR_SETUP, S_WR_HOLD: begin
        ce_d    = 1'b0;
        drive_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_d    = 1'b0;
        we_d    = 1'b0;
        drive_d = 1'b1;
      end
      S_RD_SETUP: ce_d = 1'b0;
      S_RD_ACCESS: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
      end
      default: ;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset to idle pin values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      drive_q     <= 1'b0;
      ce_q        <= 1'b1;
      we_q        <= 1'b1;
      oe_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      drive_q     <= drive_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign sram_address       = addr_q;
  assign sram_chip_enable   = ce_q;
  assign sram_write_enable  = we_q;
  assign sram_output_enable = oe_q;
  assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: three instances (WAIT_CYCLES = 2, 1, 5), each
// attached to a behavioural asynchronous SRAM with a weak pull-up on the bus,
// so a released bus reads as all ones.
module tb_sram_controller;

  localparam int WV [3] = '{2, 1, 5};

  logic clk;
  logic reset;

  logic        req_valid [3];
  logic        req_write [3];
  logic [7:0]  req_addr  [3];
  logic [15:0] req_wdata [3];
  wire         req_ready [3];
  wire         rsp_valid [3];
  wire  [15:0] rsp_rdata [3];
  wire  [7:0]  s_addr    [3];
  wire  [15:0] s_data    [3];
  wire         s_ce      [3];
  wire         s_we      [3];
  wire         s_oe      [3];

  // Reference memory contents as seen by the system (updated per completed write).
  logic [15:0] ref_mem [3][256];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  bit mon_en    = 0;
  logic        we_prev   [3];
  logic [7:0]  hold_addr [3];
  logic [15:0] hold_data [3];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wire  [15:0] data_bus;
    logic [15:0] mem [256];

    sram_controller_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bif ();

    assign bif.req_valid = req_valid[gi];
    assign bif.req_write = req_write[gi];
    assign bif.req_addr  = req_addr[gi];
    assign bif.req_wdata = req_wdata[gi];
    assign req_ready[gi] = bif.req_ready;
    assign rsp_valid[gi] = bif.rsp_valid;
    assign rsp_rdata[gi] = bif.rsp_rdata;

    sram_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(WV[gi])) u_dut (
      .clk                (clk),
      .reset              (reset),
      .bus                (bif),
      .sram_address       (s_addr[gi]),
      .sram_data          (data_bus),
      .sram_chip_enable   (s_ce[gi]),
      .sram_write_enable  (s_we[gi]),
      .sram_output_enable (s_oe[gi])
    );

    // The device drives whenever OE is low and WE is high, regardless of CE.
    assign data_bus = (!s_oe[gi] && s_we[gi]) ? mem[s_addr[gi]] : 16'hzzzz;
    for (genvar bi = 0; bi < 16; bi++) begin : g_pu
      pullup pu (data_bus[bi]);
    end
    assign s_data[gi] = data_bus;

    // Device array: reset-initialised contents, stores while CE and WE are low.
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 256; i++) mem[i] <= (i == 124) ? 16'h3779 : 16'h0000;
      end else if (!s_ce[gi] && !s_we[gi]) begin
        mem[s_addr[gi]] <= data_bus;
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d (W=%0d) cycle %0d: got %0h, expected %0h", name, k, WV[k], cyc, act, exp);
    end
  endtask

  task automatic ref_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++) ref_mem[k][i] = (i == 124) ? 16'h3779 : 16'h0000;
  endtask

  // Advance to the next falling edge and run the always-on pin protocol checks.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc > 40000) begin
      $display("FAIL cycle_budget: reached %0d cycles, limit 40000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        check("we_oe_both_low", k, 32'(!s_we[k] && !s_oe[k]), 0);
        if (!s_oe[k]) check("bus_during_oe", k, 32'(s_data[k]), 32'(ref_mem[k][s_addr[k]]));
        if (!s_we[k] && !we_prev[k]) begin
          check("addr_stable_we_low", k, 32'(s_addr[k]), 32'(hold_addr[k]));
          check("data_stable_we_low", k, 32'(s_data[k]), 32'(hold_data[k]));
        end
        if (!s_we[k] && we_prev[k]) begin
          hold_addr[k] = s_addr[k];
          hold_data[k] = s_data[k];
        end
        we_prev[k] = s_we[k];
      end
    end
  endtask

  // One complete request on instance k with cycle-by-cycle pin expectations
  // derived from the SETUP / W-cycle pulse / HOLD-or-DONE / IDLE timeline.
  task automatic run_op(input int k, input bit wr, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd);
    int w;
    int guard;
    int rsp_cyc;
    logic [15:0] rdata_before;
    bit exp_ce, exp_we, exp_oe;
    w = WV[k];
    guard = 0;
    while (req_ready[k] !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("ready_before_accept", k, 32'(req_ready[k]), 1);
    rdata_before = rsp_rdata[k];
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    tick();
    req_valid[k] = 1'b0;
    req_write[k] = 1'($urandom);
    req_addr[k]  = 8'($urandom);
    req_wdata[k] = 16'($urandom);
    rsp_cyc = 0;
    for (int c = 1; c <= w + 3; c++) begin
      exp_ce = !(c <= (wr ? w + 2 : w + 1));
      exp_we = !(wr && c >= 2 && c <= w + 1);
      exp_oe = !(!wr && c >= 2 && c <= w + 1);
      check("chip_enable", k, 32'(s_ce[k]), 32'(exp_ce));
      check("write_enable", k, 32'(s_we[k]), 32'(exp_we));
      check("output_enable", k, 32'(s_oe[k]), 32'(exp_oe));
      check("req_ready", k, 32'(req_ready[k]), 32'(c == w + 3));
      check("rsp_valid", k, 32'(rsp_valid[k]), 32'(!wr && c == w + 2));
      if (rsp_valid[k] === 1'b1 && rsp_cyc == 0) rsp_cyc = c;
      if (!wr && c == w + 2) check("rsp_rdata_strobe", k, 32'(rsp_rdata[k]), 32'(exp_rd));
      if (c <= (wr ? w + 2 : w + 1)) check("sram_address", k, 32'(s_addr[k]), 32'(addr));
      if (wr && c <= w + 2) check("bus_write_data", k, 32'(s_data[k]), 32'(wdata));
      else if (!(c >= 2 && c <= w + 1)) check("bus_released", k, 32'(s_data[k]), 32'h0000FFFF);
      if (c < w + 3) tick();
    end
    check("rsp_latency", k, 32'(rsp_cyc), wr ? 0 : 32'(w + 2));
    check("rsp_rdata_hold", k, 32'(rsp_rdata[k]), wr ? 32'(rdata_before) : 32'(exp_rd));
    if (wr) ref_mem[k][addr] = wdata;
  endtask

  initial begin
    logic [7:0]  bb_addr [3];
    logic [15:0] bb_data [3];
    int acc_cyc [3];
    int acc;
    int k;
    bit wr;
    logic [7:0]  a;
    logic [15:0] d;

    vecs[0]  = '{1'b0, 8'd124,  16'h0000, 16'h3779};
    vecs[1]  = '{1'b0, 8'd5,    16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 8'h10,   16'hA5C3, 16'h0000};
    vecs[3]  = '{1'b0, 8'h10,   16'h0000, 16'hA5C3};
    vecs[4]  = '{1'b1, 8'h00,   16'h1234, 16'h0000};
    vecs[5]  = '{1'b1, 8'hFF,   16'hBEEF, 16'h0000};
    vecs[6]  = '{1'b0, 8'hFF,   16'h0000, 16'hBEEF};
    vecs[7]  = '{1'b0, 8'h00,   16'h0000, 16'h1234};
    vecs[8]  = '{1'b1, 8'h10,   16'h0F0F, 16'h0000};
    vecs[9]  = '{1'b0, 8'h10,   16'h0000, 16'h0F0F};
    vecs[10] = '{1'b0, 8'd124,  16'h0000, 16'h3779};

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 16'h0000;
      we_prev[i]   = 1'b1;
      hold_addr[i] = 8'h00;
      hold_data[i] = 16'h0000;
    end

    // Reset held for two cycles: idle pins, bus released, no response.
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", i, 32'(req_ready[i]), 1);
      check("rst_ce", i, 32'(s_ce[i]), 1);
      check("rst_we", i, 32'(s_we[i]), 1);
      check("rst_oe", i, 32'(s_oe[i]), 1);
      check("rst_bus_released", i, 32'(s_data[i]), 32'h0000FFFF);
      check("rst_rsp_valid", i, 32'(rsp_valid[i]), 0);
      check("rst_address", i, 32'(s_addr[i]), 0);
      check("rst_rdata", i, 32'(rsp_rdata[i]), 0);
    end
    reset = 1'b0;
    ref_reset();
    mon_en = 1'b1;

    // Table of directed requests on the W=2 instance.
    for (int i = 0; i < 11; i++) begin
      $display("vec %0d: %s addr=%02h wdata=%04h exp=%04h", i, vecs[i].wr ? "WR" : "RD",
               vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      run_op(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // req_valid held high across three writes; busy-time valid is ignored.
    bb_addr = '{8'hFF, 8'h00, 8'h80};
    bb_data = '{16'h1357, 16'h2468, 16'h9ABC};
    acc = 0;
    acc_cyc = '{0, 0, 0};
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (acc == 3) break;
      req_addr[0]  = bb_addr[acc];
      req_wdata[0] = bb_data[acc];
      if (req_ready[0] === 1'b1) begin
        acc_cyc[acc] = c;
        acc++;
      end
      tick();
    end
    req_valid[0] = 1'b0;
    check("b2b_accepts", 0, 32'(acc), 3);
    check("b2b_spacing_1", 0, 32'(acc_cyc[1] - acc_cyc[0]), 32'(WV[0] + 3));
    check("b2b_spacing_2", 0, 32'(acc_cyc[2] - acc_cyc[1]), 32'(WV[0] + 3));
    $display("b2b: accepts=%0d at cycles %0d %0d %0d", acc, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    for (int i = 0; i < 3; i++) ref_mem[0][bb_addr[i]] = bb_data[i];
    for (int i = 0; i < 3; i++) begin
      $display("b2b readback addr=%02h exp=%04h", bb_addr[i], bb_data[i]);
      run_op(0, 1'b0, bb_addr[i], 16'h0000, bb_data[i]);
    end

    // W=1 and W=5 instances: preloaded read plus write/read pairs.
    for (int i = 1; i < 3; i++) begin
      $display("sweep dut%0d W=%0d: read 124, write/read %02h", i, WV[i], 8'h40 + 8'(i));
      run_op(i, 1'b0, 8'd124, 16'h0000, 16'h3779);
      run_op(i, 1'b1, 8'h40 + 8'(i), 16'h5A5A + 16'(i), 16'h0000);
      run_op(i, 1'b0, 8'h40 + 8'(i), 16'h0000, 16'h5A5A + 16'(i));
    end

    // Random traffic across all instances, expected data from the reference memory.
    for (int n = 0; n < 60; n++) begin
      k  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      d  = 16'($urandom);
      $display("rand %0d: dut%0d %s addr=%02h wdata=%04h exp=%04h", n, k, wr ? "WR" : "RD",
               a, d, ref_mem[k][a]);
      run_op(k, wr, a, d, ref_mem[k][a]);
    end

    // Reset asserted during the write pulse aborts the operation.
    $display("reset during WR_PULSE on dut0");
    while (req_ready[0] !== 1'b1 && acc < 100) begin
      tick();
      acc++;
    end
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 8'h33;
    req_wdata[0] = 16'hDEAD;
    tick();
    req_valid[0] = 1'b0;
    tick();
    check("midrst_in_pulse", 0, 32'(s_we[0]), 0);
    reset = 1'b1;
    tick();
    check("midrst_we", 0, 32'(s_we[0]), 1);
    check("midrst_ce", 0, 32'(s_ce[0]), 1);
    check("midrst_oe", 0, 32'(s_oe[0]), 1);
    check("midrst_bus_released", 0, 32'(s_data[0]), 32'h0000FFFF);
    check("midrst_req_ready", 0, 32'(req_ready[0]), 1);
    check("midrst_rsp_valid", 0, 32'(rsp_valid[0]), 0);
    reset = 1'b0;
    ref_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_rsp", 0, 32'(rsp_valid[0]), 0);
    end
    run_op(0, 1'b0, 8'd124, 16'h0000, 16'h3779);
    run_op(0, 1'b1, 8'h33, 16'h0C0C, 16'h0000);
    run_op(0, 1'b0, 8'h33, 16'h0000, 16'h0C0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Synchronous initiator for the team's asynchronous single-port SRAM device (active-low chip/write/output enables, bidirectional data bus). It accepts single-word read/write requests over a valid/ready handshake and sequences the SRAM pins with setup, pulse and hold phases. Read data is returned on a one-cycle response strobe. The block sits between system logic (e.g. the divider datapath) and the SRAM pins.

Parameters:
DATA_WIDTH, 16, width of the SRAM word and of the data bus.
ADDR_WIDTH, 8, SRAM address width; the device depth is 2**ADDR_WIDTH.
WAIT_CYCLES, 2, number of clock cycles WE or OE is held low. Must be at least 1; 0 is an elaboration error.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request; a transfer occurs when req_valid and req_ready are both high.
req_write  input  1  1 = write, 0 = read; sampled on accept.
req_addr  input  ADDR_WIDTH  word address; sampled on accept.
req_wdata  input  DATA_WIDTH  write data; sampled on accept.
rsp_valid  output  1  one-cycle strobe; rsp_rdata is valid while it is high.
rsp_rdata  output  DATA_WIDTH  read data; holds its value until the next read completes.
sram_address  output  ADDR_WIDTH  SRAM address pins.
sram_data  inout  DATA_WIDTH  SRAM data bus; driven only during write phases, otherwise high-impedance.
sram_chip_enable  output  1  active low.
sram_write_enable  output  1  active low.
sram_output_enable  output  1  active low.

Behaviour:
- All outputs are registered, so the SRAM control pins are glitch-free. The data-bus drive enable is also registered.
- Reset (synchronous): state goes to IDLE. Chip, write and output enables all go to 1. sram_data goes to high-impedance. sram_address = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 1.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_ACCESS, RD_DONE. A wait counter (width clog2(WAIT_CYCLES+1)) times the PULSE and ACCESS states.
- IDLE: req_ready = 1, CE = 1, WE = 1, OE = 1, bus is high-impedance. On accept, latch addr/wdata/write, drop req_ready, and go to WR_SETUP or RD_SETUP. req_ready stays low in every non-IDLE state.
- Timing from the accept edge E0:
  - Cycle 1 (SETUP): address valid, CE = 0, WE = 1, OE = 1. On a write, data is driven; on a read, the bus is high-impedance.
  - Cycles 2 to W+1: write holds WE = 0 with data driven; read holds OE = 0 with the bus released.
  - Cycle W+2: write is in WR_HOLD with WE = 1 and CE = 0, data still driven and address unchanged. Read is in RD_DONE with CE = 1 and OE = 1, rsp_valid = 1, and rsp_rdata = sram_data as captured at the edge ending the last ACCESS cycle.
  - Cycle W+3: IDLE, req_ready = 1.
- Back-to-back throughput is one operation per W+3 cycles.
- Address and write data never change while WE = 0. OE and WE are never low simultaneously. The controller never drives sram_data while OE = 0; this is the bus-turnaround guarantee, because the device drives the bus whenever OE = 0 and WE = 1, independent of CE.
- Writes produce no response strobe.
- req_valid held high while req_ready = 0 is ignored. Request inputs may change freely outside the accept cycle.
- Reset mid-operation: the operation is aborted on that edge and pins return to idle values on the next cycle. No rsp_valid is issued. The word at the aborted write address is undefined. Memory-content initialisation is not this block's job.
- Address range 0 to 2**ADDR_WIDTH-1 is passed through unchanged; there is no wrap or bounds logic.

Test Plan:
- Reset then idle: hold reset 2 cycles -> req_ready = 1, CE/WE/OE = 1/1/1, sram_data = Z, rsp_valid = 0.
- Read preloaded word: with the SRAM model reset-initialised, read addr 124 with W = 2 -> OE low for exactly 2 cycles, rsp_valid pulse at cycle 4 after accept, rsp_rdata = 0x3779. A read of addr 5 returns 0x0000.
- Write then read: write 0xA5C3 to addr 0x10, then read 0x10 -> WE low for 2 cycles with address and data stable from cycle 1 through cycle 4, and the read returns 0xA5C3. A checker flags any cycle with WE = 0 and OE = 0 together, and any cycle where the bus is driven while OE = 0.
- Back-to-back and ignored valid: hold req_valid high across 3 writes (addr 0xFF, 0x00, 0x80) -> exactly 3 accepts, spaced 5 cycles apart. A follow-up read of 0xFF returns the first write's data.
- Reset mid-write: assert reset during WR_PULSE -> the next cycle shows WE = 1, CE = 1, bus Z, req_ready = 1, and no rsp_valid.
- Parameter sweep: with W = 1 and W = 5, read latency is 3 and 7 cycles respectively, matching the W+2 rule.
